// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer definitions: tag range, entry layout and the
// mispredict redirect helper.
package reorder_buffer_pkg;

    localparam int ROB_SIZE  = 16;
    localparam int ROB_WIDTH = 4;
    localparam int ROBRange  = ROB_SIZE - 1;

    localparam logic True  = 1'b1;
    localparam logic False = 1'b0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        is_branch;
        logic        is_store;
        logic        pred_taken;
        logic [31:0] val;
        logic        taken;
        logic [31:0] target;
    } rob_entry_t;

    function automatic logic [31:0] redirect_pc(input logic        taken,
                                                 input logic [31:0] target,
                                                 input logic [31:0] pc);
        return taken ? target : pc + 32'd4;
    endfunction

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order retirement queue: allocates tags at the tail, captures CDB
// results, retires one entry per cycle from the head and flushes on mispredict.
module reorder_buffer #(
    parameter int ROB_SIZE  = reorder_buffer_pkg::ROBRange + 1,
    parameter int ROB_WIDTH = reorder_buffer_pkg::ROB_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 issue_valid,
    input  logic [4:0]           issue_rd,
    input  logic [31:0]          issue_pc,
    input  logic                 issue_isBranch,
    input  logic                 issue_isStore,
    input  logic                 issue_predTaken,
    output logic                 rob_full,
    output logic [ROB_WIDTH-1:0] rob_freeTag,
    input  logic [ROB_WIDTH-1:0] query_tag1,
    input  logic [ROB_WIDTH-1:0] query_tag2,
    output logic                 query_ready1,
    output logic                 query_ready2,
    output logic [31:0]          query_val1,
    output logic [31:0]          query_val2,
    input  logic                 cdb_valid,
    input  logic [ROB_WIDTH-1:0] cdb_tag,
    input  logic [31:0]          cdb_val,
    input  logic                 cdb_taken,
    input  logic [31:0]          cdb_target,
    output logic                 commit_valid,
    output logic [4:0]           ROB_rd,
    output logic [ROB_WIDTH-1:0] ROB_rdTag,
    output logic [31:0]          ROB_rdVal,
    output logic                 store_commit,
    output logic [ROB_WIDTH-1:0] store_tag,
    output logic                 rollback,
    output logic [31:0]          rollback_pc
);
    import reorder_buffer_pkg::*;

    rob_entry_t           ent_q [ROB_SIZE];
    rob_entry_t           ent_d [ROB_SIZE];
    logic [ROB_SIZE-1:0]  ready_q, ready_d;
    logic [ROB_WIDTH-1:0] head_q, head_d;
    logic [ROB_WIDTH-1:0] tail_q, tail_d;
    logic [ROB_WIDTH:0]   count_q, count_d;

    logic                 commit_valid_q, commit_valid_d;
    logic [4:0]           rob_rd_q, rob_rd_d;
    logic [ROB_WIDTH-1:0] rob_rd_tag_q, rob_rd_tag_d;
    logic [31:0]          rob_rd_val_q, rob_rd_val_d;
    logic                 store_commit_q, store_commit_d;
    logic [ROB_WIDTH-1:0] store_tag_q, store_tag_d;
    logic                 rollback_q, rollback_d;
    logic [31:0]          rollback_pc_q, rollback_pc_d;

    logic                 full;
    logic                 accept_issue;
    logic                 retire;
    logic                 mispredict;
    logic                 cdb_hit;
    logic [ROB_WIDTH-1:0] cdb_offset;
    logic                 fwd1, fwd2;
    rob_entry_t           head_ent;

    // Occupancy comes from count alone; head == tail is ambiguous when full.
    assign full         = (count_q == (ROB_WIDTH+1)'(ROB_SIZE));
    assign accept_issue = issue_valid && !full;
    assign head_ent     = ent_q[head_q];
    assign retire       = (count_q != '0) && ready_q[head_q];
    assign mispredict   = retire && head_ent.is_branch &&
                          (head_ent.taken != head_ent.pred_taken);
    assign cdb_offset   = cdb_tag - head_q;
    assign cdb_hit      = cdb_valid && ({1'b0, cdb_offset} < count_q);

    assign fwd1         = cdb_valid && (cdb_tag == query_tag1);
    assign fwd2         = cdb_valid && (cdb_tag == query_tag2);
    assign query_ready1 = ready_q[query_tag1] || fwd1;
    assign query_ready2 = ready_q[query_tag2] || fwd2;
    assign query_val1   = fwd1 ? cdb_val : ent_q[query_tag1].val;
    assign query_val2   = fwd2 ? cdb_val : ent_q[query_tag2].val;

    always_comb begin
        ent_d          = ent_q;
        ready_d        = ready_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        commit_valid_d = commit_valid_q;
        rob_rd_d       = rob_rd_q;
        rob_rd_tag_d   = rob_rd_tag_q;
        rob_rd_val_d   = rob_rd_val_q;
        store_commit_d = store_commit_q;
        store_tag_d    = store_tag_q;
        rollback_d     = rollback_q;
        rollback_pc_d  = rollback_pc_q;

        if (rdy) begin
            commit_valid_d = False;
            store_commit_d = False;
            rollback_d     = False;

            if (retire) begin
                if (head_ent.is_branch) begin
                    if (mispredict) begin
                        rollback_d    = True;
                        rollback_pc_d = redirect_pc(head_ent.taken, head_ent.target, head_ent.pc);
                    end
                end else if (head_ent.is_store) begin
                    store_commit_d = True;
                    store_tag_d    = head_q;
                end else begin
                    commit_valid_d = True;
                    rob_rd_d       = head_ent.rd;
                    rob_rd_tag_d   = head_q;
                    rob_rd_val_d   = head_ent.val;
                end
            end

            // A flush wipes the queue, so this cycle's issue and CDB are dropped.
            if (mispredict) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
                ready_d = '0;
            end else begin
                if (accept_issue) begin
                    ent_d[tail_q].rd         = issue_rd;
                    ent_d[tail_q].pc         = issue_pc;
                    ent_d[tail_q].is_branch  = issue_isBranch;
                    ent_d[tail_q].is_store   = issue_isStore;
                    ent_d[tail_q].pred_taken = issue_predTaken;
                    ready_d[tail_q]          = False;
                    tail_d                   = tail_q + ROB_WIDTH'(1);
                end
                if (cdb_hit) begin
                    ent_d[cdb_tag].val    = cdb_val;
                    ent_d[cdb_tag].taken  = cdb_taken;
                    ent_d[cdb_tag].target = cdb_target;
                    ready_d[cdb_tag]      = True;
                end
                if (retire) begin
                    head_d = head_q + ROB_WIDTH'(1);
                end
                count_d = count_q + (ROB_WIDTH+1)'(accept_issue) - (ROB_WIDTH+1)'(retire);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q        <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            commit_valid_q <= 1'b0;
            rob_rd_q       <= '0;
            rob_rd_tag_q   <= '0;
            rob_rd_val_q   <= '0;
            store_commit_q <= 1'b0;
            store_tag_q    <= '0;
            rollback_q     <= 1'b0;
            rollback_pc_q  <= '0;
        end else begin
            ready_q        <= ready_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            commit_valid_q <= commit_valid_d;
            rob_rd_q       <= rob_rd_d;
            rob_rd_tag_q   <= rob_rd_tag_d;
            rob_rd_val_q   <= rob_rd_val_d;
            store_commit_q <= store_commit_d;
            store_tag_q    <= store_tag_d;
            rollback_q     <= rollback_d;
            rollback_pc_q  <= rollback_pc_d;
        end
    end

    // Payload needs no reset: it is only read while the ready bit is set.
    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

    assign rob_full     = full;
    assign rob_freeTag  = tail_q;
    assign commit_valid = commit_valid_q;
    assign ROB_rd       = rob_rd_q;
    assign ROB_rdTag    = rob_rd_tag_q;
    assign ROB_rdVal    = rob_rd_val_q;
    assign store_commit = store_commit_q;
    assign store_tag    = store_tag_q;
    assign rollback     = rollback_q;
    assign rollback_pc  = rollback_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: expected retirements are queued at issue
// and matched against the commit/store/rollback pulses as they appear.
module tb_reorder_buffer;

    localparam int K_REG   = 0;
    localparam int K_STORE = 1;
    localparam int K_ROLL  = 2;
    localparam int K_NONE  = 3;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        issue_valid, issue_isBranch, issue_isStore, issue_predTaken;
    logic [4:0]  issue_rd;
    logic [31:0] issue_pc;
    logic        rob_full;
    logic [3:0]  rob_freeTag;
    logic [3:0]  query_tag1, query_tag2;
    logic        query_ready1, query_ready2;
    logic [31:0] query_val1, query_val2;
    logic        cdb_valid, cdb_taken;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_val, cdb_target;
    logic        commit_valid, store_commit, rollback;
    logic [4:0]  ROB_rd;
    logic [3:0]  ROB_rdTag, store_tag;
    logic [31:0] ROB_rdVal, rollback_pc;

    typedef struct {
        int          kind;
        logic [4:0]  rd;
        logic [3:0]  tag;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          mon_kind;
    int          checks = 0;
    int          errors = 0;
    int          reg_pulses = 0;
    logic [3:0]  tb_tail;
    logic [31:0] pend_val [16];

    reorder_buffer dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_pc(issue_pc),
        .issue_isBranch(issue_isBranch), .issue_isStore(issue_isStore),
        .issue_predTaken(issue_predTaken),
        .rob_full(rob_full), .rob_freeTag(rob_freeTag),
        .query_tag1(query_tag1), .query_tag2(query_tag2),
        .query_ready1(query_ready1), .query_ready2(query_ready2),
        .query_val1(query_val1), .query_val2(query_val2),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .cdb_taken(cdb_taken), .cdb_target(cdb_target),
        .commit_valid(commit_valid), .ROB_rd(ROB_rd), .ROB_rdTag(ROB_rdTag),
        .ROB_rdVal(ROB_rdVal), .store_commit(store_commit), .store_tag(store_tag),
        .rollback(rollback), .rollback_pc(rollback_pc)
    );

    always #5 clk = ~clk;

    // Pulses are consumed only while rdy is high, exactly like the real consumers.
    always @(negedge clk) begin
        if (!rst && rdy && (commit_valid || store_commit || rollback)) begin
            mon_kind = commit_valid ? K_REG : (store_commit ? K_STORE : K_ROLL);
            if (commit_valid) reg_pulses++;
            checks++;
            if ((int'(commit_valid) + int'(store_commit) + int'(rollback)) != 1) begin
                errors++;
                $display("FAIL pulse_exclusive: commit=%0b store=%0b rollback=%0b, expected one-hot",
                         commit_valid, store_commit, rollback);
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: kind=%0d rd=%0d tag=%0d val=%h, expected none",
                         mon_kind, ROB_rd, ROB_rdTag, ROB_rdVal);
            end else begin
                mon_e = sb.pop_front();
                if (mon_kind != mon_e.kind) begin
                    errors++;
                    $display("FAIL pulse_kind: got %0d, expected %0d (tag %0d)", mon_kind, mon_e.kind, mon_e.tag);
                end else if (mon_kind == K_REG) begin
                    if ({ROB_rd, ROB_rdTag, ROB_rdVal} !== {mon_e.rd, mon_e.tag, mon_e.val}) begin
                        errors++;
                        $display("FAIL commit_data: rd=%0d tag=%0d val=%h, expected rd=%0d tag=%0d val=%h",
                                 ROB_rd, ROB_rdTag, ROB_rdVal, mon_e.rd, mon_e.tag, mon_e.val);
                    end
                end else if (mon_kind == K_STORE) begin
                    if (store_tag !== mon_e.tag) begin
                        errors++;
                        $display("FAIL store_tag: got %0d, expected %0d", store_tag, mon_e.tag);
                    end
                end else begin
                    if (rollback_pc !== mon_e.val) begin
                        errors++;
                        $display("FAIL rollback_pc: got %h, expected %h", rollback_pc, mon_e.val);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        issue_valid = 0; issue_rd = '0; issue_pc = '0;
        issue_isBranch = 0; issue_isStore = 0; issue_predTaken = 0;
        cdb_valid = 0; cdb_tag = '0; cdb_val = '0; cdb_taken = 0; cdb_target = '0;
    endtask

    task automatic apply_reset();
        rst = 1; rdy = 1;
        clear_inputs();
        tick(); tick();
        rst = 0;
        tb_tail = '0;
        sb.delete();
    endtask

    task automatic issue_op(input logic [4:0] rd, input logic [31:0] pc, input logic br,
                            input logic st, input logic pt, input int kind, input logic [31:0] val);
        checks++;
        if (rob_freeTag !== tb_tail) begin
            errors++;
            $display("FAIL free_tag: got %0d, expected %0d", rob_freeTag, tb_tail);
        end
        issue_valid = 1; issue_rd = rd; issue_pc = pc;
        issue_isBranch = br; issue_isStore = st; issue_predTaken = pt;
        pend_val[tb_tail] = val;
        if (kind == K_REG || kind == K_STORE)
            sb.push_back('{kind: kind, rd: rd, tag: tb_tail, val: val});
        tick();
        issue_valid = 0;
        tb_tail = tb_tail + 4'd1;
    endtask

    task automatic cdb_write(input logic [3:0] tag, input logic [31:0] val,
                             input logic taken, input logic [31:0] target);
        cdb_valid = 1; cdb_tag = tag; cdb_val = val; cdb_taken = taken; cdb_target = target;
        tick();
        cdb_valid = 0;
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        for (int i = 0; i < max_cycles && sb.size() != 0; i++) tick();
        repeat (3) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d retirements pending, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({commit_valid, store_commit, rollback} !== 3'b000) begin
            errors++;
            $display("FAIL reset_pulses: got %b, expected 000", {commit_valid, store_commit, rollback});
        end
        checks++;
        if ({ROB_rd, ROB_rdTag, ROB_rdVal, store_tag, rollback_pc} !== '0) begin
            errors++;
            $display("FAIL reset_data: rd=%0d tag=%0d val=%h stag=%0d rpc=%h, expected all 0",
                     ROB_rd, ROB_rdTag, ROB_rdVal, store_tag, rollback_pc);
        end
        checks++;
        if (rob_full !== 1'b0 || rob_freeTag !== 4'd0) begin
            errors++;
            $display("FAIL reset_queue: full=%0b free=%0d, expected 0/0", rob_full, rob_freeTag);
        end
    endtask

    task automatic test_in_order();
        int p0;
        p0 = reg_pulses;
        issue_op(5'd1, 32'h0, 0, 0, 0, K_REG, 32'h1111_0001);
        issue_op(5'd2, 32'h4, 0, 0, 0, K_REG, 32'h2222_0002);
        issue_op(5'd3, 32'h8, 0, 0, 0, K_REG, 32'h3333_0003);
        cdb_write(4'd2, pend_val[2], 0, '0);
        cdb_write(4'd0, pend_val[0], 0, '0);
        cdb_write(4'd1, pend_val[1], 0, '0);
        wait_drain("in_order", 20);
        checks++;
        if (reg_pulses - p0 != 3) begin
            errors++;
            $display("FAIL in_order_count: got %0d commits, expected 3", reg_pulses - p0);
        end
    endtask

    task automatic test_query_forward();
        query_tag1 = 4'd5; query_tag2 = 4'd6;
        cdb_valid = 1; cdb_tag = 4'd5; cdb_val = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (query_ready1 !== 1'b1 || query_val1 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL query_forward: ready=%0b val=%h, expected 1/deadbeef", query_ready1, query_val1);
        end
        checks++;
        if (query_ready2 !== 1'b0) begin
            errors++;
            $display("FAIL query_other: ready=%0b, expected 0", query_ready2);
        end
        tick();
        cdb_valid = 0; query_tag2 = 4'd5;
        #1;
        checks++;
        if (query_ready2 !== 1'b0) begin
            errors++;
            $display("FAIL cdb_unoccupied: ready=%0b, expected 0", query_ready2);
        end
    endtask

    task automatic test_full_wrap();
        apply_reset();
        for (int i = 0; i < 16; i++)
            issue_op(5'(i + 1), 32'(i * 4), 0, 0, 0, K_REG, 32'hF000_0000 + 32'(i));
        checks++;
        if (rob_full !== 1'b1 || rob_freeTag !== tb_tail) begin
            errors++;
            $display("FAIL full_after_16: full=%0b free=%0d, expected 1/%0d", rob_full, rob_freeTag, tb_tail);
        end
        issue_valid = 1; issue_rd = 5'd31; issue_pc = 32'hBAD;
        tick();
        issue_valid = 0;
        checks++;
        if (rob_full !== 1'b1 || rob_freeTag !== tb_tail) begin
            errors++;
            $display("FAIL issue_while_full: full=%0b free=%0d, expected 1/%0d", rob_full, rob_freeTag, tb_tail);
        end
        cdb_write(4'd0, pend_val[0], 0, '0);
        checks++;
        if (rob_full !== 1'b1) begin
            errors++;
            $display("FAIL full_before_retire: full=%0b, expected 1", rob_full);
        end
        tick();
        checks++;
        if (rob_full !== 1'b0 || rob_freeTag !== 4'd0) begin
            errors++;
            $display("FAIL retire_frees: full=%0b free=%0d, expected 0/0", rob_full, rob_freeTag);
        end
        issue_op(5'd20, 32'h80, 0, 0, 0, K_REG, 32'hB000_0020);
        checks++;
        if (rob_full !== 1'b1) begin
            errors++;
            $display("FAIL refill: full=%0b, expected 1", rob_full);
        end
        // Head retires while full: the simultaneous issue must still be refused.
        cdb_write(4'd1, pend_val[1], 0, '0);
        issue_valid = 1; issue_rd = 5'd30; issue_pc = 32'hBAD;
        tick();
        issue_valid = 0;
        checks++;
        if (rob_full !== 1'b0 || rob_freeTag !== tb_tail) begin
            errors++;
            $display("FAIL full_issue_commit: full=%0b free=%0d, expected 0/%0d", rob_full, rob_freeTag, tb_tail);
        end
        cdb_write(4'd2, pend_val[2], 0, '0);
        issue_op(5'd21, 32'h84, 0, 0, 0, K_REG, 32'hB000_0021);
        checks++;
        if (rob_full !== 1'b0 || rob_freeTag !== tb_tail) begin
            errors++;
            $display("FAIL count15_issue_commit: full=%0b free=%0d, expected 0/%0d", rob_full, rob_freeTag, tb_tail);
        end
        issue_op(5'd22, 32'h88, 0, 0, 0, K_REG, 32'hB000_0022);
        checks++;
        if (rob_full !== 1'b1) begin
            errors++;
            $display("FAIL count15_then_issue: full=%0b, expected 1", rob_full);
        end
        for (int k = 0; k < 16; k++)
            cdb_write(4'(k + 3), pend_val[4'(k + 3)], 0, '0);
        wait_drain("full_wrap", 40);
    endtask

    task automatic test_rollback(input logic pred, input logic taken, input logic [31:0] target,
                                 input logic [31:0] exp_pc, input string name);
        apply_reset();
        issue_op(5'd0, 32'h100, 1, 0, pred, K_NONE, 32'h0);
        for (int k = 0; k < 4; k++)
            issue_op(5'(k + 10), 32'h104 + 32'(4 * k), 0, 0, 0, K_NONE, 32'hC0 + 32'(k));
        sb.push_back('{kind: K_ROLL, rd: 5'd0, tag: 4'd0, val: exp_pc});
        for (int k = 1; k <= 4; k++)
            cdb_write(4'(k), pend_val[k], 0, '0);
        cdb_write(4'd0, 32'h0, taken, target);
        // Flush cycle: this issue and CDB write must be dropped.
        issue_valid = 1; issue_rd = 5'd29; issue_pc = 32'h900;
        cdb_valid = 1; cdb_tag = 4'd1; cdb_val = 32'h1234;
        tick();
        clear_inputs();
        wait_drain(name, 10);
        tb_tail = '0;
        query_tag1 = 4'd1;
        #1;
        checks++;
        if (rob_full !== 1'b0 || rob_freeTag !== 4'd0 || query_ready1 !== 1'b0) begin
            errors++;
            $display("FAIL %s_flushed: full=%0b free=%0d ready1=%0b, expected 0/0/0",
                     name, rob_full, rob_freeTag, query_ready1);
        end
        issue_op(5'd9, 32'h200, 0, 0, 0, K_REG, 32'h9999_0009);
        cdb_write(4'd0, pend_val[0], 0, '0);
        wait_drain({name, "_restart"}, 10);
    endtask

    task automatic test_store();
        int p0;
        logic [3:0] tb_br, tb_st, tb_op;
        p0 = reg_pulses;
        tb_br = tb_tail;
        issue_op(5'd0, 32'h400, 1, 0, 1, K_NONE, 32'h0);
        tb_st = tb_tail;
        issue_op(5'd7, 32'h404, 0, 1, 0, K_STORE, 32'h0);
        tb_op = tb_tail;
        issue_op(5'd0, 32'h408, 0, 0, 0, K_REG, 32'h5A5A_0000);
        cdb_write(tb_br, 32'h0, 1, 32'h500);
        cdb_write(tb_st, 32'h0, 0, '0);
        cdb_write(tb_op, pend_val[tb_op], 0, '0);
        wait_drain("store", 10);
        checks++;
        if (reg_pulses - p0 != 1) begin
            errors++;
            $display("FAIL store_reg_count: got %0d commits, expected 1", reg_pulses - p0);
        end
    endtask

    task automatic test_rdy_hold();
        int p0;
        logic [3:0] t;
        p0 = reg_pulses;
        t = tb_tail;
        issue_op(5'd7, 32'h600, 0, 0, 0, K_REG, 32'h7777_0007);
        cdb_write(t, pend_val[t], 0, '0);
        tick();
        rdy = 0;
        issue_valid = 1; issue_rd = 5'd28; issue_pc = 32'h700;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (commit_valid !== 1'b1 || ROB_rdTag !== t || ROB_rdVal !== 32'h7777_0007 || rob_freeTag !== tb_tail) begin
                errors++;
                $display("FAIL rdy_hold_%0d: commit=%0b tag=%0d val=%h free=%0d, expected 1/%0d/77770007/%0d",
                         i, commit_valid, ROB_rdTag, ROB_rdVal, rob_freeTag, t, tb_tail);
            end
            if (i < 3) tick();
        end
        issue_valid = 0;
        rdy = 1;
        tick();
        checks++;
        if (commit_valid !== 1'b0 || reg_pulses - p0 != 1) begin
            errors++;
            $display("FAIL rdy_release: commit=%0b count=%0d, expected 0/1", commit_valid, reg_pulses - p0);
        end
        wait_drain("rdy_hold", 5);
    endtask

    initial begin
        rst = 1; rdy = 1;
        query_tag1 = '0; query_tag2 = '0;
        clear_inputs();
        test_reset();
        test_in_order();
        test_query_forward();
        test_full_wrap();
        test_rollback(1'b0, 1'b1, 32'h200, 32'h200, "rollback_taken");
        test_rollback(1'b1, 1'b0, 32'h300, 32'h104, "rollback_not_taken");
        test_store();
        test_rdy_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order retirement queue between the dispatcher/CDB and the register file.
- Allocates one tag per issued instruction and captures results from the common data bus (CDB).
- Retires at most one instruction per cycle, in program order, driving the register-file commit port.
- Detects branch mispredictions at the head and raises a flush (rollback) with the corrected PC.

Parameters:
ROB_SIZE, 16, number of entries; must be a power of two.
ROB_WIDTH, 4, tag width = log2(ROB_SIZE); matches the shared ROB tag range.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; all state holds when low
issue_valid  in  1  allocate an entry at the tail this cycle
issue_rd  in  5  destination register (0 = none)
issue_pc  in  32  instruction PC
issue_isBranch  in  1  entry is a conditional branch
issue_isStore  in  1  entry is a store
issue_predTaken  in  1  predictor decision for a branch
rob_full  out  1  no free entry (combinational)
rob_freeTag  out  ROB_WIDTH  tag that the next issue receives (= tail); sent to regFile rename
query_tag1/2  in  ROB_WIDTH  operand producer tags from the dispatcher
query_ready1/2  out  1  the queried entry has its result (combinational)
query_val1/2  out  32  result of the queried entry (combinational)
cdb_valid  in  1  a result is broadcast
cdb_tag  in  ROB_WIDTH  producing entry
cdb_val  in  32  result value
cdb_taken  in  1  actual branch outcome
cdb_target  in  32  actual branch target
commit_valid  out  1  register commit pulse
ROB_rd  out  5  committed destination register
ROB_rdTag  out  ROB_WIDTH  committed tag
ROB_rdVal  out  32  committed value
store_commit  out  1  head store retired; the load/store buffer may perform it
store_tag  out  ROB_WIDTH  tag of the retired store
rollback  out  1  flush pulse to every unit
rollback_pc  out  32  corrected fetch PC

Behaviour:
- Reset: head = tail = count = 0; all entry ready bits 0.
  - commit_valid, store_commit and rollback are 0.
  - ROB_rd, ROB_rdTag, ROB_rdVal, store_tag and rollback_pc are 0.
- rdy low: every register holds, including the pulse outputs. Consumers also gate on rdy, so each pulse is sampled exactly once.
- rob_full = (count == ROB_SIZE). Issue while full is ignored; the dispatcher must not issue when rob_full is high.
- Issue (issue_valid && !full):
  - The entry at tail stores rd, pc, isBranch, isStore and predTaken; ready is cleared.
  - tail = tail + 1, wrapping modulo ROB_SIZE.
- CDB: if cdb_valid and the entry at cdb_tag is occupied, it stores val/taken/target and sets ready. A CDB write to an unoccupied entry is ignored.
- Query ports:
  - query_ready = ready of the queried entry, or (cdb_valid && cdb_tag == query_tag), forwarding from the CDB in the same cycle.
  - query_val selects the CDB value when forwarding.
- Commit (head occupied and ready), registered, one per cycle. Outputs are valid for the one cycle after the edge that retires the entry.
  - Non-branch, non-store:
    - commit_valid = 1, ROB_rd = rd, ROB_rdTag = head, ROB_rdVal = val.
    - rd = 0 still commits; the regFile ignores x0.
  - Store: store_commit = 1, store_tag = head; commit_valid = 0.
  - Branch with taken == predTaken: retires silently; no pulse.
  - Branch with taken != predTaken:
    - rollback = 1; rollback_pc = taken ? target : pc + 4.
    - Next state: head = tail = count = 0 and all ready bits cleared.
    - Issue and CDB inputs in that same cycle are discarded.
- Pulse outputs default to 0 on every rdy cycle unless set as above.
- count arithmetic:
  - issue and commit in the same cycle: unchanged.
  - issue only: +1.
  - commit only: −1.
  - rollback: 0.
- Head entry becomes ready via the CDB at edge E: it may retire at edge E+1 at the earliest; there is no same-edge bypass.
- Wrap-around: head and tail are ROB_WIDTH-bit counters, so overflow is the wrap. Full versus empty is resolved by count, never by comparing head and tail.
- Entries become busy/unready again after rollback. Tags are reused freely; the regFile clears a tag only on a tag-matched commit.

Decomposition:
- Shared defines: ROBRange, ROB_SIZE, ROB_WIDTH, True/False.
- The entry storage arrays stay inside this module.
- No sub-module is needed. Commit/rollback selection is a single always block.

Test Plan:
- Reset, then issue 3 ALU ops (rd = 1, 2, 3), with the CDB writing tags 2, 0, 1 in that order → commits rd 1, 2, 3 in order on consecutive cycles with the correct values; commit_valid is exactly 3 pulses.
- Issue 16 ops without writeback → rob_full = 1 and a 17th issue is ignored. Retire one → rob_full = 0 next cycle; the next issue receives tag 0 (wrap-around).
- Branch at pc = 0x100, predTaken = 0, CDB taken = 1, target = 0x200, with 4 younger ops → rollback pulse, rollback_pc = 0x200, count = 0, no younger commit. Repeat with predTaken = 1, taken = 0 → rollback_pc = 0x104.
- Query tag 5 while the CDB broadcasts tag 5 with value 0xDEADBEEF in the same cycle → query_ready = 1 and query_val = 0xDEADBEEF combinationally.
- Store at head made ready → store_commit = 1, store_tag = head, commit_valid = 0.
- Full ROB with simultaneous issue and commit → no issue is accepted while full. With count = 15, simultaneous issue and commit → count stays 15.
- Hold rdy = 0 for 3 cycles mid-commit → outputs frozen, exactly one commit observed.
